// File: rtl/lv2_req_arbiter_if.sv
// Request/command bundle shared by the L1 request ports, the LV2 arbiter and the LV2 front end.
`ifndef ADDR_WID_LV2
`define ADDR_WID_LV2 32
`endif

interface lv2_req_arbiter_if #(
    parameter int unsigned NUM_REQ  = 4,
    parameter int unsigned ADDR_WID = `ADDR_WID_LV2
);
    logic [NUM_REQ-1:0]          req_rd;
    logic [NUM_REQ-1:0]          req_wr;
    logic [NUM_REQ*ADDR_WID-1:0] req_addr;
    logic                        lv2_done;
    logic [NUM_REQ-1:0]          gnt;
    logic [NUM_REQ-1:0]          ack;
    logic                        cmd_rd;
    logic                        cmd_wr;
    logic [ADDR_WID-1:0]         address;
    logic                        busy;

    // Arbiter side
    modport slave (
        input  req_rd, req_wr, req_addr, lv2_done,
        output gnt, ack, cmd_rd, cmd_wr, address, busy
    );

    // Requester / LV2 side
    modport master (
        output req_rd, req_wr, req_addr, lv2_done,
        input  gnt, ack, cmd_rd, cmd_wr, address, busy
    );
endinterface

// File: rtl/lv2_req_arbiter.sv
// Round-robin arbiter that owns the single LV2 command/address path for the L1 request ports.
// One command is latched per slot and held until lv2_done; a one-cycle ack then returns to the winner.
`ifndef ADDR_WID_LV2
`define ADDR_WID_LV2 32
`endif

module lv2_req_arbiter #(
    parameter int unsigned NUM_REQ  = 4,
    parameter int unsigned ADDR_WID = `ADDR_WID_LV2
) (
    input  logic             clk,
    input  logic             rst,
    lv2_req_arbiter_if.slave bus
);
    localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(NUM_REQ - 1);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_BUSY    = 2'd1;
    localparam logic [1:0] S_RECOVER = 2'd2;

    logic [1:0]          state_q,  state_d;
    logic [PTR_W-1:0]    ptr_q,    ptr_d;
    logic [PTR_W-1:0]    win_q,    win_d;
    logic [NUM_REQ-1:0]  gnt_q,    gnt_d;
    logic [NUM_REQ-1:0]  ack_q,    ack_d;
    logic                cmd_rd_q, cmd_rd_d;
    logic                cmd_wr_q, cmd_wr_d;
    logic [ADDR_WID-1:0] addr_q,   addr_d;
    logic                busy_q,   busy_d;

    logic [NUM_REQ-1:0]  pending_c;
    logic                any_pending_c;
    logic [PTR_W-1:0]    pick_c;
    logic [ADDR_WID-1:0] req_addr_arr [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_addr
        assign req_addr_arr[g] = bus.req_addr[g*ADDR_WID +: ADDR_WID];
    end

    assign pending_c     = bus.req_rd | bus.req_wr;
    assign any_pending_c = |pending_c;

    // First pending requester at or after the priority pointer, wrapping around
    always_comb begin
        logic        found_v;
        int unsigned idx_v;
        found_v = 1'b0;
        idx_v   = 0;
        pick_c  = ptr_q;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            idx_v = (32'(ptr_q) + k) % NUM_REQ;
            if (!found_v && pending_c[PTR_W'(idx_v)]) begin
                found_v = 1'b1;
                pick_c  = PTR_W'(idx_v);
            end
        end
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        win_d    = win_q;
        gnt_d    = gnt_q;
        ack_d    = '0;
        cmd_rd_d = cmd_rd_q;
        cmd_wr_d = cmd_wr_q;
        addr_d   = addr_q;
        busy_d   = busy_q;

        case (state_q)
            S_IDLE: begin
                if (any_pending_c) begin
                    state_d  = S_BUSY;
                    win_d    = pick_c;
                    gnt_d    = NUM_REQ'(1) << pick_c;
                    busy_d   = 1'b1;
                    cmd_rd_d = bus.req_rd[pick_c];
                    // A simultaneous read and write is serviced as a read
                    cmd_wr_d = bus.req_wr[pick_c] & ~bus.req_rd[pick_c];
                    addr_d   = req_addr_arr[pick_c];
                end
            end
            S_BUSY: begin
                if (bus.lv2_done) begin
                    state_d  = S_RECOVER;
                    ack_d    = gnt_q;
                    gnt_d    = '0;
                    cmd_rd_d = 1'b0;
                    cmd_wr_d = 1'b0;
                    addr_d   = '0;
                    busy_d   = 1'b0;
                    ptr_d    = (win_q == LAST_IDX) ? '0 : win_q + PTR_W'(1);
                end
            end
            // Gap cycle so the winner's stale request is never sampled
            S_RECOVER: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d  = S_IDLE;
                gnt_d    = '0;
                cmd_rd_d = 1'b0;
                cmd_wr_d = 1'b0;
                addr_d   = '0;
                busy_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            ptr_q    <= '0;
            win_q    <= '0;
            gnt_q    <= '0;
            ack_q    <= '0;
            cmd_rd_q <= 1'b0;
            cmd_wr_q <= 1'b0;
            addr_q   <= '0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            win_q    <= win_d;
            gnt_q    <= gnt_d;
            ack_q    <= ack_d;
            cmd_rd_q <= cmd_rd_d;
            cmd_wr_q <= cmd_wr_d;
            addr_q   <= addr_d;
            busy_q   <= busy_d;
        end
    end

    assign bus.gnt     = gnt_q;
    assign bus.ack     = ack_q;
    assign bus.cmd_rd  = cmd_rd_q;
    assign bus.cmd_wr  = cmd_wr_q;
    assign bus.address = addr_q;
    assign bus.busy    = busy_q;

    // Output invariants of the command path
    always @(posedge clk) begin
        if (!rst) begin
            assert (!(cmd_rd_q && cmd_wr_q));
            assert (!((|gnt_q) && (|ack_q)));
            assert ($onehot0(gnt_q));
            assert ($onehot0(ack_q));
        end
    end
endmodule
